data_memory_pipe: RTL and testbench

- Parametrised successor to the single-cycle 32-bit data memory.
- Adds a valid/ready request/response interface and registered (1-cycle) read data.
- Configurable data width (32 or 64) and depth; RISC-V load/store funct3 modes, including RV64 doubleword and LWU.
- Sits between the MEM stage of the pipeline and a word-organised RAM array; detects misaligned, out-of-range and illegal-mode accesses.

---
 rtl/dmem_pkg.sv | 53 +++++
 rtl/dmem_ram.sv | 46 ++++
 rtl/data_memory_pipe.sv | 136 +++++++++++++
 tb/tb_data_memory_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory: funct3 mode codes,
// byte-lane mask generation and load-data extraction/extension.
// Helpers work at 64-bit width; callers keep the low DATA_W bits.
package dmem_pkg;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_D  = 3'b011;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;
    localparam logic [2:0] MODE_WU = 3'b110;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [2:0] mode);
        case (mode[1:0])
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Byte lanes touched by an access of this size at this byte offset.
    function automatic logic [7:0] lane_mask(input logic [2:0] mode, input logic [2:0] offset);
        logic [7:0] base;
        case (mode[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    // Pull the addressed lanes down to bit 0 and extend to 64 bits.
    function automatic logic [63:0] load_extract(input logic [2:0] mode, input logic [63:0] word,
                                                 input logic [2:0] offset);
        logic [63:0] sh;
        sh = word >> {offset, 3'b000};
        case (mode)
            MODE_B:  return {{56{sh[7]}}, sh[7:0]};
            MODE_H:  return {{48{sh[15]}}, sh[15:0]};
            MODE_W:  return {{32{sh[31]}}, sh[31:0]};
            MODE_D:  return sh;
            MODE_BU: return {56'd0, sh[7:0]};
            MODE_HU: return {48'd0, sh[15:0]};
            MODE_WU: return {32'd0, sh[31:0]};
            default: return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x DATA_W word array with per-byte write enables and a registered
// read port. Kept separate so the array can be inferred as RAM.
module dmem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data
);
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    // Byte-lane write; array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) mem_q[idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // Read word is captured only on a load accept so it holds under backpressure.
    always_comb begin
        rd_d = rd_q;
        if (rd_en) rd_d = mem_q[idx];
    end

    // Read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_d;
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/data_memory_pipe.sv
// Data memory between the MEM stage and a word-organised RAM.
// valid/ready request and response, one registered response slot, 1-cycle loads.
// Optional DMEM_ERR_EN: when defined, misaligned / out-of-range / illegal-mode
// accesses fault; when undefined, resp_err is 0, the word index wraps,
// offsets are truncated to natural alignment and illegal modes act as W.
module data_memory_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic              accept;
    logic              illegal;
    logic              acc_err;
    logic [2:0]        eff_mode;
    logic [2:0]        eff_off;
    logic [ADDR_W-1:0] word_addr;
    logic [IDX_W-1:0]  widx;
    logic [7:0]        mask8;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_data;
    logic [63:0]       ext;

    logic       resp_valid_d, resp_valid_q;
    logic       resp_err_d,   resp_err_q;
    logic       resp_load_d,  resp_load_q;
    logic [2:0] mode_d,       mode_q;
    logic [2:0] off_d,        off_q;

    assign req_ready = !resp_valid_q || resp_ready;
    assign accept    = req_valid && req_ready;
    assign word_addr = req_addr >> OFF_W;

    // Stores only support B/H/W/D; D and WU need a 64-bit word.
    assign illegal = (req_mode == 3'b111)
                  || ((DATA_W == 32) && (req_mode == MODE_D || req_mode == MODE_WU))
                  || (req_we && req_mode[2]);

    // Request decode: effective mode, lane offset, word index and fault.
    always_comb begin
`ifdef DMEM_ERR_EN
        eff_mode = req_mode;
        eff_off  = 3'(req_addr[OFF_W-1:0]);
        widx     = word_addr[IDX_W-1:0];
        acc_err  = illegal
                || ((req_addr[2:0] & align_mask(req_mode)) != 3'b000)
                || (word_addr >= DEPTH_A);
`else
        eff_mode = illegal ? MODE_W : req_mode;
        eff_off  = 3'(req_addr[OFF_W-1:0]) & ~align_mask(eff_mode);
        widx     = IDX_W'(word_addr % DEPTH_A);
        acc_err  = 1'b0;
`endif
    end

    assign mask8    = lane_mask(eff_mode, eff_off);
    assign wdata_sh = req_wdata << {eff_off, 3'b000};

    dmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept && req_we && !acc_err),
        .wr_be   (mask8[BYTES-1:0]),
        .idx     (widx),
        .wr_data (wdata_sh),
        .rd_en   (accept && !req_we && !acc_err),
        .rd_data (rd_data)
    );

    // Response slot: load on accept, drain on resp_ready, otherwise hold.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_load_d  = resp_load_q;
        mode_d       = mode_q;
        off_d        = off_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_err_d   = acc_err;
            resp_load_d  = !req_we && !acc_err;
            mode_d       = eff_mode;
            off_d        = eff_off;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Response registers; reset drops any pending response at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_load_q  <= 1'b0;
            mode_q       <= MODE_B;
            off_q        <= 3'd0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_load_q  <= resp_load_d;
            mode_q       <= mode_d;
            off_q        <= off_d;
        end
    end

    // Extension runs on the registered read word, so data follows the slot.
    always_comb begin
        ext        = load_extract(mode_q, 64'(rd_data), off_q);
        resp_data  = (resp_valid_q && resp_load_q) ? ext[DATA_W-1:0] : '0;
        resp_err   = resp_valid_q && resp_err_q;
        resp_valid = resp_valid_q;
    end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Bench for data_memory_pipe: a 32-bit and a 64-bit instance driven with the
// same requests, checked every cycle against a byte-array reference model.
module tb_data_memory_pipe;
    localparam int DEPTH_T = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_we, resp_ready;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
    logic [31:0] data_a;
    logic [63:0] data_b;

    data_memory_pipe #(.DATA_W(32), .DEPTH(DEPTH_T), .ADDR_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a),
        .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(vld_a), .resp_ready(resp_ready),
        .resp_data(data_a), .resp_err(err_a));

    data_memory_pipe #(.DATA_W(64), .DEPTH(DEPTH_T), .ADDR_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_b),
        .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(vld_b), .resp_ready(resp_ready),
        .resp_data(data_b), .resp_err(err_b));

    int tests = 0;
    int fails = 0;

    // Reference model: memory as bytes, k=0 is the 32-bit instance, k=1 the 64-bit one.
    logic [7:0]  mem [2][512];
    logic        exp_valid [2];
    logic        exp_err [2];
    logic [63:0] exp_data [2];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int msize(input logic [2:0] m);
        case (m)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd3:       return 8;
            default:    return 4;
        endcase
    endfunction

    function automatic void eval(input int k, input logic we, input logic [2:0] mode,
                                 input logic [31:0] addr, output logic err,
                                 output logic [63:0] data, output logic wr,
                                 output int base, output int sz);
        int w;
        logic illegal;
        logic [2:0] m;
        longint unsigned a, idx, off, v;
        w = (k == 0) ? 4 : 8;
        a = longint'(addr);
        illegal = (mode == 3'd7) || (w == 4 && (mode == 3'd3 || mode == 3'd6)) || (we && mode >= 3'd4);
        m = mode;
        idx = a / w;
        off = a % w;
        err = 1'b0;
        data = 64'd0;
        wr = 1'b0;
`ifdef DMEM_ERR_EN
        if (illegal || (a % msize(mode)) != 0 || idx >= DEPTH_T) err = 1'b1;
`else
        if (illegal) m = 3'd2;
        idx = idx % DEPTH_T;
        off = off - (off % msize(m));
`endif
        sz = msize(m);
        base = int'(idx * w + off);
        if (err) return;
        if (we) begin
            wr = 1'b1;
        end else begin
            v = 0;
            for (int i = sz - 1; i >= 0; i--) v = (v << 8) | longint'(mem[k][base + i]);
            if (m <= 3'd2 && sz < 8 && ((v >> (sz * 8 - 1)) & 1) == 1)
                v = v | (~64'd0 << (sz * 8));
            data = (w == 4) ? (v & 64'hFFFF_FFFF) : v;
        end
    endfunction

    // Model step: same accept rule as the interface, applied to whole transactions.
    always @(posedge clk or negedge rst_n) begin
        logic acc, e, wr;
        logic [63:0] d;
        int base, sz;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                exp_valid[k] <= 1'b0;
                exp_err[k]   <= 1'b0;
                exp_data[k]  <= 64'd0;
            end
        end else begin
            acc = req_valid && (!exp_valid[0] || resp_ready);
            for (int k = 0; k < 2; k++) begin
                if (acc) begin
                    eval(k, req_we, req_mode, req_addr, e, d, wr, base, sz);
                    exp_valid[k] <= 1'b1;
                    exp_err[k]   <= e;
                    exp_data[k]  <= d;
                    if (wr) for (int i = 0; i < sz; i++) mem[k][base + i] <= req_wdata[8*i +: 8];
                end else if (resp_ready) begin
                    exp_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always begin
        @(negedge clk);
        #1;
        chk("a_req_ready", 64'(rdy_a), 64'(!exp_valid[0] || resp_ready));
        chk("b_req_ready", 64'(rdy_b), 64'(!exp_valid[1] || resp_ready));
        chk("a_resp_valid", 64'(vld_a), 64'(exp_valid[0]));
        chk("b_resp_valid", 64'(vld_b), 64'(exp_valid[1]));
        if (exp_valid[0]) begin
            chk("a_resp_data", 64'(data_a), exp_data[0]);
            chk("a_resp_err", 64'(err_a), 64'(exp_err[0]));
        end
        if (exp_valid[1]) begin
            chk("b_resp_data", data_b, exp_data[1]);
            chk("b_resp_err", 64'(err_b), 64'(exp_err[1]));
        end
    end

    // One request with resp_ready=1; returns at the negedge where its response is visible.
    task automatic issue(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [63:0] wd);
        req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wd;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 512; i++) mem[k][i] = 8'h00;
        req_valid = 1'b0; req_we = 1'b0; req_mode = 3'd0; req_addr = 32'd0;
        req_wdata = 64'd0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_resp_valid", 64'(vld_a), 64'd0);
        chk("reset_resp_data", 64'(data_a), 64'd0);
        chk("reset_resp_err", 64'(err_a), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 64'(rdy_a), 64'd1);

        // Clear both arrays so the bench does not depend on power-up contents.
        for (int i = 0; i < 512; i += 4) issue(1'b1, 3'd2, 32'(i), 64'd0);

        // Word store/load round trip.
        issue(1'b1, 3'd2, 32'd0, 64'hDEADBEEF);
        issue(1'b0, 3'd2, 32'd0, 64'd0);
        chk("t1_valid", 64'(vld_a), 64'd1);
        chk("t1_lw", 64'(data_a), 64'hDEADBEEF);
        chk("t1_err", 64'(err_a), 64'd0);
        chk("t1_lw_64", data_b, 64'hFFFFFFFF_DEADBEEF);

        // Byte store and extensions.
        issue(1'b1, 3'd0, 32'd13, 64'hAA);
        issue(1'b0, 3'd0, 32'd13, 64'd0);
        chk("t2_lb", 64'(data_a), 64'hFFFFFFAA);
        issue(1'b0, 3'd4, 32'd13, 64'd0);
        chk("t2_lbu", 64'(data_a), 64'h000000AA);
        issue(1'b0, 3'd2, 32'd12, 64'd0);
        chk("t2_lw12", 64'(data_a), 64'h0000AA00);
        chk("t2_lw12_64", data_b, 64'h0000AA00);

        // Halfword store, extensions, back-to-back store then load.
        issue(1'b1, 3'd1, 32'd22, 64'hABCD);
        issue(1'b0, 3'd1, 32'd22, 64'd0);
        chk("t3_lh", 64'(data_a), 64'hFFFFABCD);
        issue(1'b0, 3'd5, 32'd22, 64'd0);
        chk("t3_lhu", 64'(data_a), 64'h0000ABCD);
        issue(1'b1, 3'd1, 32'd22, 64'h1357);
        issue(1'b0, 3'd5, 32'd22, 64'd0);
        chk("t3_b2b", 64'(data_a), 64'h00001357);

        // Backpressure: held response, blocked store must not land.
        issue(1'b1, 3'd2, 32'd4, 64'h12345678);
        issue(1'b0, 3'd2, 32'd4, 64'd0);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_mode = 3'd2; req_addr = 32'd4; req_wdata = 64'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_hold_data", 64'(data_a), 64'h12345678);
            chk("t4_hold_valid", 64'(vld_a), 64'd1);
            chk("t4_hold_ready", 64'(rdy_a), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        issue(1'b0, 3'd2, 32'd4, 64'd0);
        chk("t4_after", 64'(data_a), 64'h12345678);

`ifdef DMEM_ERR_EN
        issue(1'b0, 3'd2, 32'd2, 64'd0);
        chk("t5_mis_err", 64'(err_a), 64'd1);
        chk("t5_mis_data", 64'(data_a), 64'd0);
        issue(1'b1, 3'd2, 32'd2, 64'h55);
        chk("t5_st_err", 64'(err_a), 64'd1);
        issue(1'b0, 3'd2, 32'd0, 64'd0);
        chk("t5_unchanged", 64'(data_a), 64'hDEADBEEF);
        issue(1'b0, 3'd2, 32'(DEPTH_T * 4), 64'd0);
        chk("t5_oor", 64'(err_a), 64'd1);
        issue(1'b0, 3'd7, 32'd0, 64'd0);
        chk("t5_mode7", 64'(err_a), 64'd1);
        chk("t5_mode7_64", 64'(err_b), 64'd1);
`else
        issue(1'b0, 3'd2, 32'd2, 64'd0);
        chk("t5_trunc", 64'(data_a), 64'hDEADBEEF);
        chk("t5_noerr", 64'(err_a), 64'd0);
`endif

        // Doubleword on the 64-bit instance.
        issue(1'b1, 3'd3, 32'd8, 64'h01234567_89ABCDEF);
        issue(1'b0, 3'd3, 32'd8, 64'd0);
        chk("t6_ld", data_b, 64'h01234567_89ABCDEF);
        issue(1'b0, 3'd6, 32'd12, 64'd0);
        chk("t6_lwu", data_b, 64'h00000000_01234567);
        issue(1'b0, 3'd2, 32'd12, 64'd0);
        chk("t6_lw", data_b, 64'h00000000_01234567);

        // Reset while a response is pending.
        issue(1'b0, 3'd2, 32'd8, 64'd0);
        resp_ready = 1'b0;
        @(negedge clk);
        chk("t6_pending", 64'(vld_b), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_a", 64'(vld_a), 64'd0);
        chk("t6_rst_b", 64'(vld_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        issue(1'b0, 3'd2, 32'd8, 64'd0);
        chk("t6_kept", data_b, 64'hFFFFFFFF_89ABCDEF);

        // Random traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom % 10) < 7;
            req_we    = $urandom % 2;
            req_mode  = 3'($urandom % 8);
            case ($urandom % 8)
                0:       req_addr = $urandom;
                1:       req_addr = $urandom % 600;
                default: req_addr = ($urandom % 512) & 32'hFFFF_FFF8 | (($urandom % 2) ? 32'd4 : 32'd0);
            endcase
            req_wdata  = {$urandom, $urandom};
            resp_ready = ($urandom % 4) != 0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
